multiplication_arbiter: RTL and testbench
=========================================

Name: multiplication_arbiter

Overview:
- Shares one fast_multiplication unit between NUM_REQUESTERS issue ports in the complex ALU.
- Grants requests round-robin and drives operands and sign bits into the multiplier.
- Records each grant's requester ID in an in-order ID queue, then steers each product back to the requester that issued it.
- Placed between the complex-ALU issue ports and fast_multiplication; no other logic touches the multiplier handshake.

Parameters:
- NUM_REQUESTERS, 2, number of requester ports (power of two, 2..8)
- OPERAND_WIDTH_IN_BITS, 64, operand magnitude width
- PRODUCT_WIDTH_IN_BITS, 128, product width (2 x operand)
- MAX_IN_FLIGHT, 4, depth of the ID queue; maximum outstanding multiplications (power of two)

Ports:
- clk_in  in  1  single clock, rising edge
- reset_in  in  1  asynchronous, active-low reset
- request_valid_in  in  NUM_REQUESTERS  per-requester request valid
- request_ready_out  out  NUM_REQUESTERS  per-requester grant; one-hot or zero
- request_multiplier_sign_bit_in  in  NUM_REQUESTERS  sign bit per requester
- request_multiplier_in  in  NUM_REQUESTERS*OPERAND_WIDTH_IN_BITS  packed operands, requester 0 in LSBs
- request_multicand_sign_bit_in  in  NUM_REQUESTERS  sign bit per requester
- request_multicand_in  in  NUM_REQUESTERS*OPERAND_WIDTH_IN_BITS  packed operands
- result_valid_out  out  NUM_REQUESTERS  one-cycle pulse, one-hot
- result_product_sign_bit_out  out  1  registered product sign
- result_product_out  out  PRODUCT_WIDTH_IN_BITS  registered product
- mul_is_ready_in  in  1  from fast_multiplication is_ready_out
- mul_is_valid_out  out  1  to fast_multiplication is_valid_in
- mul_multiplier_sign_bit_out / mul_multiplier_out  out  1 / OPERAND_WIDTH_IN_BITS  to multiplier
- mul_multicand_sign_bit_out / mul_multicand_out  out  1 / OPERAND_WIDTH_IN_BITS  to multiplier
- mul_is_valid_in  in  1  from fast_multiplication is_valid_out
- mul_product_sign_bit_in / mul_product_in  in  1 / PRODUCT_WIDTH_IN_BITS  from multiplier

Behaviour:
Reset (reset_in low, asynchronous):
- All outputs go to 0.
- Round-robin pointer is cleared to requester 0.
- ID queue is emptied and the in-flight count is set to 0.

Issue:
- can_issue = mul_is_ready_in & (in_flight < MAX_IN_FLIGHT) & any request_valid_in.
- When can_issue holds, the grant goes to the first valid requester at or after the RR pointer, wrapping around.
- Grant is combinational: request_ready_out[g]=1 and mul_is_valid_out=1 in the same cycle, with the mux-selected operands and sign bits driven.
- A transfer occurs when valid & ready are both high. On the transfer edge:
  - push g onto the ID queue;
  - in_flight++;
  - RR pointer <- g+1 mod NUM_REQUESTERS.
- When can_issue is false, request_ready_out=0 and mul_is_valid_out=0. The pointer holds.
- Requesters hold their operands stable until granted.

Return:
- The multiplier completes in order and has no backpressure.
- On mul_is_valid_in, pop the ID queue head h. Next cycle, result_valid_out[h]=1 with the registered product and sign.
- Return latency is 1 cycle after mul_is_valid_in.
- If mul_is_valid_in arrives while the queue is empty: drop the product, leave result_valid_out at 0, and assert sticky internal error flag (simulation $display).

Simultaneous events:
- Push and pop in the same cycle leave in_flight unchanged. Both queue pointers advance and wrap modulo MAX_IN_FLIGHT.
- A pop frees a slot only from the next cycle. At in_flight==MAX_IN_FLIGHT no grant is given, even when a pop happens that cycle.

Reset mid-operation:
- In-flight IDs are discarded.
- The multiplier is reset by the same reset_in, so no stale products arrive afterwards.

Decomposition:
- Constants MULTIPLICATION_REQUESTERS and MULTIPLICATION_MAX_IN_FLIGHT go in parameters.h, as do the ID width, defined as clog2 of NUM_REQUESTERS.
- One sub-module, multiplication_id_fifo: a synchronous FIFO with parameterised depth and width.
  - Push/pop and full/empty flags, plus an occupancy count.
  - Same clock and same asynchronous active-low reset.
- Round-robin selection and operand muxing stay in the top module.

Test Plan:
1. Single request: requester 0 sends 7 x 2, both signs 0 -> granted in the same cycle; result_valid_out=2'b01, product 14, sign 0.
2. Contention: both valid every cycle, requester 0 sends 69x98, requester 1 sends 123x123 -> grants alternate 0,1,0,1; products 6762 to requester 0 and 15129 to requester 1, in issue order.
3. Queue full: mul_is_ready_in=1, 5 back-to-back requests, no products returned -> 4 grants, 5th ready stays 0 until a mul_is_valid_in pop; grant the cycle after the pop.
4. Multiplier busy: mul_is_ready_in=0 for 10 cycles with requests pending -> no grants, RR pointer unchanged; resumes at pointer on ready.
5. Signs: 255 (sign 1) x 98 (sign 0) -> product 24990, sign 1, routed to the issuing requester.
6. Reset mid-flight: 3 outstanding, pull reset_in low asynchronously -> all outputs 0 immediately; after release, 999x989 returns 988011 with correct routing.

Source files
------------

// File: rtl/multiplication_arbiter_pkg.sv
// Shared constants for the multiplier arbiter slice: requester count, queue depth, widths.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package multiplication_arbiter_pkg;

    localparam int MULTIPLICATION_REQUESTERS    = 2;
    localparam int MULTIPLICATION_MAX_IN_FLIGHT = 4;
    localparam int MULTIPLICATION_OPERAND_WIDTH = 64;
    localparam int MULTIPLICATION_PRODUCT_WIDTH = 128;

    // Width of a requester ID; a single requester still needs one bit to hold it.
    function automatic int id_width(input int num_ids);
        return (num_ids > 1) ? $clog2(num_ids) : 1;
    endfunction

    localparam int MULTIPLICATION_ID_WIDTH = id_width(MULTIPLICATION_REQUESTERS);

endpackage

// File: rtl/multiplication_id_fifo.sv
// In-order queue of requester IDs for multiplications that are still in flight.
// Latency: push visible at the head one cycle later; pop_data_out is the combinational head.
// Backpressure: pushes while full and pops while empty are ignored; full_out/count_out tell the producer.
//
// Ports: clk_in, reset_in (async active-low), push_in/push_data_in, pop_in/pop_data_out,
//        full_out, empty_out, count_out (occupancy 0..DEPTH).
module multiplication_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic                     push_in,
    input  logic [WIDTH-1:0]         push_data_in,
    input  logic                     pop_in,
    output logic [WIDTH-1:0]         pop_data_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_out    = (count_out == '0);
    assign full_out     = (count_out == FULL_COUNT);
    assign do_push      = push_in & ~full_out;
    assign do_pop       = pop_in & ~empty_out;
    assign pop_data_out = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_out <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count_out <= count_out + 1'b1;
            else if (do_pop && !do_push) count_out <= count_out - 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_data_in;
    end

endmodule

// File: rtl/multiplication_arbiter.sv
// Round-robin sharing of one in-order multiplier between NUM_REQUESTERS issue ports, with product steering.
// Latency: grant is combinational in the request cycle; result appears one cycle after mul_is_valid_in.
// Backpressure: no grant while the multiplier is not ready or MAX_IN_FLIGHT products are outstanding.
//
// Ports: clk_in, reset_in (async active-low); request_* issue side (valid/ready per requester, packed
//        operands with requester 0 in the LSBs); result_* return side (one-hot valid pulse, registered
//        product and sign); mul_* handshake to and from fast_multiplication.
module multiplication_arbiter
    import multiplication_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS        = MULTIPLICATION_REQUESTERS,
    parameter int OPERAND_WIDTH_IN_BITS = MULTIPLICATION_OPERAND_WIDTH,
    parameter int PRODUCT_WIDTH_IN_BITS = MULTIPLICATION_PRODUCT_WIDTH,
    parameter int MAX_IN_FLIGHT         = MULTIPLICATION_MAX_IN_FLIGHT
) (
    input  logic                                              clk_in,
    input  logic                                              reset_in,
    input  logic [NUM_REQUESTERS-1:0]                         request_valid_in,
    output logic [NUM_REQUESTERS-1:0]                         request_ready_out,
    input  logic [NUM_REQUESTERS-1:0]                         request_multiplier_sign_bit_in,
    input  logic [NUM_REQUESTERS*OPERAND_WIDTH_IN_BITS-1:0]   request_multiplier_in,
    input  logic [NUM_REQUESTERS-1:0]                         request_multicand_sign_bit_in,
    input  logic [NUM_REQUESTERS*OPERAND_WIDTH_IN_BITS-1:0]   request_multicand_in,
    output logic [NUM_REQUESTERS-1:0]                         result_valid_out,
    output logic                                              result_product_sign_bit_out,
    output logic [PRODUCT_WIDTH_IN_BITS-1:0]                  result_product_out,
    input  logic                                              mul_is_ready_in,
    output logic                                              mul_is_valid_out,
    output logic                                              mul_multiplier_sign_bit_out,
    output logic [OPERAND_WIDTH_IN_BITS-1:0]                  mul_multiplier_out,
    output logic                                              mul_multicand_sign_bit_out,
    output logic [OPERAND_WIDTH_IN_BITS-1:0]                  mul_multicand_out,
    input  logic                                              mul_is_valid_in,
    input  logic                                              mul_product_sign_bit_in,
    input  logic [PRODUCT_WIDTH_IN_BITS-1:0]                  mul_product_in
);

    localparam int ID_W  = id_width(NUM_REQUESTERS);
    localparam int CNT_W = $clog2(MAX_IN_FLIGHT) + 1;
    localparam logic [CNT_W-1:0] MAX_COUNT = MAX_IN_FLIGHT[CNT_W-1:0];

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cand_id;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  head_id;
    logic             grant_found;
    logic             can_issue;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] in_flight;
    // Sticky flag: a product arrived with no matching ID and was dropped. Debug visibility only.
    logic             drop_err;
    logic             unused_ok;

    // First valid requester at or after the pointer; power-of-two count makes the ID add wrap for free.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand_id = rr_ptr + ID_W'(i);
            if (!grant_found && request_valid_in[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    // Uses the occupancy before this edge, so a same-cycle pop does not open a slot early.
    // reset_in gates the grant so every output reads zero while reset is held.
    assign can_issue = reset_in & mul_is_ready_in & (in_flight < MAX_COUNT) & grant_found;
    assign pop       = mul_is_valid_in & ~fifo_empty;

    always_comb begin
        request_ready_out           = '0;
        mul_is_valid_out            = 1'b0;
        mul_multiplier_sign_bit_out = 1'b0;
        mul_multiplier_out          = '0;
        mul_multicand_sign_bit_out  = 1'b0;
        mul_multicand_out           = '0;
        if (can_issue) begin
            request_ready_out[grant_id] = 1'b1;
            mul_is_valid_out            = 1'b1;
            mul_multiplier_sign_bit_out = request_multiplier_sign_bit_in[grant_id];
            mul_multiplier_out          = request_multiplier_in[grant_id*OPERAND_WIDTH_IN_BITS +: OPERAND_WIDTH_IN_BITS];
            mul_multicand_sign_bit_out  = request_multicand_sign_bit_in[grant_id];
            mul_multicand_out           = request_multicand_in[grant_id*OPERAND_WIDTH_IN_BITS +: OPERAND_WIDTH_IN_BITS];
        end
    end

    multiplication_id_fifo #(
        .DEPTH (MAX_IN_FLIGHT),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .push_in      (can_issue),
        .push_data_in (grant_id),
        .pop_in       (pop),
        .pop_data_out (head_id),
        .full_out     (fifo_full),
        .empty_out    (fifo_empty),
        .count_out    (in_flight)
    );

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            rr_ptr                      <= '0;
            result_valid_out            <= '0;
            result_product_sign_bit_out <= 1'b0;
            result_product_out          <= '0;
            drop_err                    <= 1'b0;
        end else begin
            if (can_issue) rr_ptr <= grant_id + 1'b1;
            result_valid_out <= '0;
            if (pop) begin
                result_valid_out[head_id]   <= 1'b1;
                result_product_sign_bit_out <= mul_product_sign_bit_in;
                result_product_out          <= mul_product_in;
            end
            if (mul_is_valid_in && fifo_empty) drop_err <= 1'b1;
        end
    end

    // Occupancy already drives the issue limit, so the full flag has no other reader.
    assign unused_ok = ^{drop_err, fifo_full};

endmodule

// File: tb/tb_multiplication_arbiter.sv
module tb_multiplication_arbiter;

    localparam int N   = 2;
    localparam int OW  = 64;
    localparam int PW  = 128;
    localparam int MAX = 4;

    logic            clk_in = 1'b0;
    logic            reset_in;
    logic [N-1:0]    request_valid_in;
    logic [N-1:0]    request_ready_out;
    logic [N-1:0]    request_multiplier_sign_bit_in;
    logic [N*OW-1:0] request_multiplier_in;
    logic [N-1:0]    request_multicand_sign_bit_in;
    logic [N*OW-1:0] request_multicand_in;
    logic [N-1:0]    result_valid_out;
    logic            result_product_sign_bit_out;
    logic [PW-1:0]   result_product_out;
    logic            mul_is_ready_in;
    logic            mul_is_valid_out;
    logic            mul_multiplier_sign_bit_out;
    logic [OW-1:0]   mul_multiplier_out;
    logic            mul_multicand_sign_bit_out;
    logic [OW-1:0]   mul_multicand_out;
    logic            mul_is_valid_in;
    logic            mul_product_sign_bit_in;
    logic [PW-1:0]   mul_product_in;

    logic [OW-1:0] mpl [N];
    logic [OW-1:0] mcd [N];
    logic          smpl [N];
    logic          smcd [N];

    assign request_multiplier_in          = {mpl[1], mpl[0]};
    assign request_multicand_in           = {mcd[1], mcd[0]};
    assign request_multiplier_sign_bit_in = {smpl[1], smpl[0]};
    assign request_multicand_sign_bit_in  = {smcd[1], smcd[0]};

    always #5 clk_in = ~clk_in;

    multiplication_arbiter dut (
        .clk_in                         (clk_in),
        .reset_in                       (reset_in),
        .request_valid_in               (request_valid_in),
        .request_ready_out              (request_ready_out),
        .request_multiplier_sign_bit_in (request_multiplier_sign_bit_in),
        .request_multiplier_in          (request_multiplier_in),
        .request_multicand_sign_bit_in  (request_multicand_sign_bit_in),
        .request_multicand_in           (request_multicand_in),
        .result_valid_out               (result_valid_out),
        .result_product_sign_bit_out    (result_product_sign_bit_out),
        .result_product_out             (result_product_out),
        .mul_is_ready_in                (mul_is_ready_in),
        .mul_is_valid_out               (mul_is_valid_out),
        .mul_multiplier_sign_bit_out    (mul_multiplier_sign_bit_out),
        .mul_multiplier_out             (mul_multiplier_out),
        .mul_multicand_sign_bit_out     (mul_multicand_sign_bit_out),
        .mul_multicand_out              (mul_multicand_out),
        .mul_is_valid_in                (mul_is_valid_in),
        .mul_product_sign_bit_in        (mul_product_sign_bit_in),
        .mul_product_in                 (mul_product_in)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: round-robin pointer, queue of issued requester IDs, and the
    // multiplier's in-order queue of {sign, product} computed from the issued operands.
    int           m_ptr;
    int           idq[$];
    logic [PW:0]  mq[$];
    logic [N-1:0] exp_res_vld;
    logic [PW-1:0] exp_prod;
    logic         exp_sign;

    typedef struct {
        int          req;
        logic [OW-1:0] a;
        logic        sa;
        logic [OW-1:0] b;
        logic        sb;
        logic [PW-1:0] prod;
        logic        ps;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        idq.delete();
        mq.delete();
        exp_res_vld = '0;
        exp_prod    = '0;
        exp_sign    = 1'b0;
    endtask

    // One clock cycle, entered and left at posedge+1. ret asks the multiplier to return a product.
    task automatic cycle(input logic [N-1:0] vld, input logic rdy, input logic ret, output int g);
        logic [PW:0]   item;
        logic [N-1:0]  exp_rdy;
        logic [PW-1:0] pr;
        int            c;
        item = '0;
        request_valid_in = vld;
        mul_is_ready_in  = rdy;
        mul_is_valid_in  = ret;
        if (ret && mq.size() > 0) item = mq.pop_front();
        else if (ret)             item = {1'b1, 128'hdead_beef};
        {mul_product_sign_bit_in, mul_product_in} = item;
        @(negedge clk_in);
        chk("result_valid", result_valid_out, exp_res_vld);
        if (exp_res_vld != '0) begin
            chk("result_product", result_product_out, exp_prod);
            chk("result_sign", result_product_sign_bit_out, exp_sign);
        end
        g = -1;
        if (rdy && idq.size() < MAX && vld != '0)
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && vld[c]) g = c;
            end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("grant", request_ready_out, exp_rdy);
        chk("mul_valid", mul_is_valid_out, (g >= 0));
        if (g >= 0) begin
            chk("mul_multiplier", mul_multiplier_out, mpl[g]);
            chk("mul_multicand", mul_multicand_out, mcd[g]);
            chk("mul_signs", {mul_multiplier_sign_bit_out, mul_multicand_sign_bit_out}, {smpl[g], smcd[g]});
        end
        exp_res_vld = '0;
        if (ret && idq.size() > 0) begin
            exp_res_vld[idq.pop_front()] = 1'b1;
            {exp_sign, exp_prod} = item;
        end
        if (g >= 0) begin
            idq.push_back(g);
            pr = {64'b0, mpl[g]} * {64'b0, mcd[g]};
            mq.push_back({smpl[g] ^ smcd[g], pr});
            m_ptr = (g + 1) % N;
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain();
        int g;
        for (int i = 0; i < MAX + 2 && mq.size() > 0; i++) cycle('0, 1'b1, 1'b1, g);
        cycle('0, 1'b1, 1'b0, g);
    endtask

    task automatic set_ops(input int r, input logic [OW-1:0] a, input logic sa, input logic [OW-1:0] b, input logic sb);
        mpl[r] = a; smpl[r] = sa; mcd[r] = b; smcd[r] = sb;
    endtask

    initial begin
        int   g;
        logic pend [N];

        tbl[0] = '{0, 64'd7,   1'b0, 64'd2,     1'b0, 128'd14,     1'b0};
        tbl[1] = '{1, 64'd255, 1'b1, 64'd98,    1'b0, 128'd24990,  1'b1};
        tbl[2] = '{0, 64'd999, 1'b0, 64'd989,   1'b0, 128'd988011, 1'b0};
        tbl[3] = '{1, 64'd0,   1'b1, 64'd12345, 1'b1, 128'd0,      1'b0};

        // Reset held with requests and a ready multiplier: every output must stay 0.
        reset_in = 1'b0;
        mul_is_valid_in = 1'b0; mul_product_in = '0; mul_product_sign_bit_in = 1'b0;
        set_ops(0, 64'd5, 1'b1, 64'd6, 1'b1);
        set_ops(1, 64'd8, 1'b0, 64'd9, 1'b0);
        request_valid_in = 2'b11;
        mul_is_ready_in  = 1'b1;
        #2;
        chk("rst_grant", request_ready_out, '0);
        chk("rst_mul_valid", mul_is_valid_out, 1'b0);
        chk("rst_mul_operand", mul_multiplier_out, '0);
        chk("rst_result_valid", result_valid_out, '0);
        chk("rst_product", result_product_out, '0);
        model_reset();
        @(posedge clk_in);
        #1;
        reset_in = 1'b1;
        request_valid_in = '0;

        // Single transactions from the vector table, result checked against constants.
        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] onehot;
            onehot = '0;
            onehot[tbl[i].req] = 1'b1;
            set_ops(tbl[i].req, tbl[i].a, tbl[i].sa, tbl[i].b, tbl[i].sb);
            cycle(onehot, 1'b1, 1'b0, g);
            cycle('0, 1'b1, 1'b1, g);
            chk("tbl_result_valid", result_valid_out, onehot);
            chk("tbl_product", result_product_out, tbl[i].prod);
            chk("tbl_sign", result_product_sign_bit_out, tbl[i].ps);
        end
        cycle('0, 1'b1, 1'b0, g);

        // Contention: both valid every cycle, grants alternate, products return in issue order.
        set_ops(0, 64'd69, 1'b0, 64'd98, 1'b0);
        set_ops(1, 64'd123, 1'b0, 64'd123, 1'b0);
        for (int i = 0; i < 4; i++) cycle(2'b11, 1'b1, (i > 0), g);
        drain();

        // Queue full: four grants, then none until a pop, and the grant comes the cycle after it.
        set_ops(0, 64'd11, 1'b0, 64'd13, 1'b1);
        for (int i = 0; i < 6; i++) cycle(2'b01, 1'b1, 1'b0, g);
        cycle(2'b01, 1'b1, 1'b1, g);
        cycle(2'b01, 1'b1, 1'b0, g);
        drain();

        // Multiplier busy: no grants and the pointer holds until ready returns.
        cycle(2'b01, 1'b1, 1'b0, g);
        for (int i = 0; i < 10; i++) cycle(2'b11, 1'b0, 1'b0, g);
        cycle(2'b11, 1'b1, 1'b0, g);
        drain();

        // Product with nothing outstanding is dropped without a result pulse.
        cycle('0, 1'b1, 1'b1, g);
        cycle('0, 1'b1, 1'b0, g);

        // Randomised traffic: requesters hold operands until granted.
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    set_ops(i, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                               {$urandom, $urandom}, 1'($urandom_range(0, 1)));
                end
            cycle({pend[1], pend[0]}, ($urandom_range(0, 3) != 0),
                  (mq.size() > 0) && ($urandom_range(0, 2) == 0), g);
            if (g >= 0) pend[g] = 1'b0;
        end
        drain();

        // Reset mid-flight with a result showing: outputs clear at once, then normal service.
        set_ops(0, 64'd21, 1'b0, 64'd2, 1'b0);
        set_ops(1, 64'd30, 1'b0, 64'd3, 1'b0);
        for (int i = 0; i < 3; i++) cycle(2'b11, 1'b1, 1'b0, g);
        cycle('0, 1'b1, 1'b1, g);
        request_valid_in = 2'b11;
        mul_is_valid_in  = 1'b0;
        reset_in = 1'b0;
        #1;
        chk("midrst_result_valid", result_valid_out, '0);
        chk("midrst_product", result_product_out, '0);
        chk("midrst_grant", request_ready_out, '0);
        chk("midrst_mul_valid", mul_is_valid_out, 1'b0);
        model_reset();
        @(posedge clk_in);
        #1;
        reset_in = 1'b1;
        set_ops(1, 64'd999, 1'b0, 64'd989, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, g);
        cycle('0, 1'b1, 1'b1, g);
        chk("post_rst_result_valid", result_valid_out, 2'b10);
        chk("post_rst_product", result_product_out, 128'd988011);
        cycle('0, 1'b1, 1'b0, g);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
